uart_rx: RTL and testbench

Asynchronous serial receiver that deserialises 8N1 UART frames from a single RX pin into bytes, flagging each completed byte with a one-cycle valid strobe and signalling BREAK conditions. It sits directly behind the board-level UART_RX pin and feeds byte-assembly logic such as the 64-bit input collector. It uses a fixed baud rate derived from the system clock by parameters.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 16 +
 rtl/uart_rx.sv | 105 ++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults, receiver state encoding and bit-timing helper.
// Used by uart_rx and the matching transmitter.
package uart_pkg;
  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int BIT_RATE_DEFAULT = 9600;
  typedef logic [2:0] state_t;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] RECV = 3'd2;
  localparam logic [2:0] STOP = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the RX pin plus falling-edge detect.
// Ports: clk, resetn (sync, active-low); rxd async line in;
//        rxd_s synchronised line; fall one-cycle pulse on a synchronised 1->0.
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);
  logic meta, prev;
  always_ff @(posedge clk)
    if (!resetn) {meta, rxd_s, prev} <= 3'b111;
    else {meta, rxd_s, prev} <= {rxd, meta, rxd_s};
  assign fall = prev & ~rxd_s;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with valid strobe and BREAK detection.
// Ports: clk; resetn (sync, active-low); uart_rxd async RX line (idle high);
//        uart_rx_en frame-start enable; uart_rx_break BREAK pulse;
//        uart_rx_valid new-byte pulse; uart_rx_data last received byte.
// Build option: UART_RX_MAJORITY_FILTER_EN votes 2-of-3 samples around each
// bit centre instead of taking the single centre sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int BIT_RATE = BIT_RATE_DEFAULT,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data
);
  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CW = $clog2(CPB + 1);
  localparam int BW = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] NLAST = BW'(PAYLOAD_BITS - 1);
  if (STOP_BITS < 1 || CPB < 4) begin : g_bad_cfg
    $error("uart_rx: need STOP_BITS >= 1 and at least 4 clocks per bit");
  end
  state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] nbit;
  logic [PAYLOAD_BITS-1:0] shift;
  logic rxd_s, fall, bit_val, tick;
  uart_rx_sync u_sync (
    .clk(clk),
    .resetn(resetn),
    .rxd(uart_rxd),
    .rxd_s(rxd_s),
    .fall(fall)
  );
  // The decision cycle is one past the bit centre, so the current rxd_s is
  // the centre+1 sample and the history holds centre (and centre-1).
`ifdef UART_RX_MAJORITY_FILTER_EN
  logic [1:0] hist;
  always_ff @(posedge clk)
    if (!resetn) hist <= 2'b11;
    else hist <= {hist[0], rxd_s};
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
  logic hist;
  always_ff @(posedge clk)
    if (!resetn) hist <= 1'b1;
    else hist <= rxd_s;
  assign bit_val = hist;
`endif
  // START decides half a bit after the edge; later bits one full bit apart.
  assign tick = (state == START) ? (cnt == HALF) : (cnt == LAST);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      nbit <= '0;
      shift <= '0;
      uart_rx_data <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
    end else begin
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      cnt <= (state == IDLE || state == WAIT_HIGH || tick) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          nbit <= '0;
          if (uart_rx_en && fall) state <= START;
        end
        START: if (tick) state <= bit_val ? IDLE : RECV;
        RECV: if (tick) begin
          shift <= PAYLOAD_BITS'({bit_val, shift} >> 1);
          nbit <= nbit + 1'b1;
          if (nbit == NLAST) state <= STOP;
        end
        STOP: if (tick) begin
          if (bit_val) begin
            uart_rx_data <= shift;
            uart_rx_valid <= 1'b1;
            state <= IDLE;
          end else begin
            // Low stop bit: all-zero payload is BREAK, anything else is dropped.
            if (shift == '0) begin
              uart_rx_data <= '0;
              uart_rx_valid <= 1'b1;
              uart_rx_break <= 1'b1;
            end
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: if (rxd_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at a short bit period.
module tb_uart_rx;
  localparam int CLK_HZ = 1_600_000;
  localparam int BIT_RATE = 100_000;
  localparam int C = CLK_HZ / BIT_RATE;
  localparam int LAT = 2 + C / 2 + 9 * C + 1;
  logic clk = 1'b0, resetn = 1'b0, rxd = 1'b1, en = 1'b1;
  logic brk, valid;
  logic [7:0] data;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic v; logic b; logic [7:0] d; int t;} ev_t;
  typedef struct {logic [7:0] d; logic stop; logic en; logic exp_v; logic exp_b; logic [7:0] exp_d;} vec_t;
  ev_t got[$];
  ev_t exp_q[$];
  vec_t vecs[8];
  logic [7:0] last_d = '0;
  uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk),
    .resetn(resetn),
    .uart_rxd(rxd),
    .uart_rx_en(en),
    .uart_rx_break(brk),
    .uart_rx_valid(valid),
    .uart_rx_data(data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid || brk) got.push_back('{valid, brk, data, cyc});
    if (resetn && data !== last_d) begin
      total++;
      if (valid !== 1'b1) begin
        bad++;
        $display("FAIL data_hold got=%h want=%h (changed without valid)", data, last_d);
      end
    end
    last_d = data;
  end
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    idle(C);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      idle(C);
    end
    rxd = stop;
    idle(C);
    rxd = 1'b1;
  endtask
  task automatic expect_one(input string name, input logic b, input logic [7:0] d);
    check({name, "_count"}, got.size(), 1);
    if (got.size() > 0) begin
      check({name, "_valid"}, got[0].v, 1);
      check({name, "_brk"}, got[0].b, b);
      check({name, "_data"}, got[0].d, d);
    end
    got.delete();
  endtask
  task automatic expect_none(input string name);
    check({name, "_count"}, got.size(), 0);
    got.delete();
  endtask
  initial begin
    int t0, lat, gap;
    logic [7:0] d;
    logic stop;
    vecs = '{
      '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5},
      '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C},
      '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00},
      '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00},
      '{8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00},
      '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
      '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3},
      '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01}
    };
    idle(3);
    check("reset_valid", valid, 0);
    check("reset_brk", brk, 0);
    check("reset_data", data, 0);
    resetn = 1'b1;
    idle(4);
    got.delete();
    t0 = cyc + 1;
    send(8'hA5, 1'b1);
    idle(2);
    if (got.size() > 0) begin
      lat = got[0].t - t0;
      total++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
        bad++;
        $display("FAIL latency got=%0d want=%0d+-1", lat, LAT);
      end
    end
    expect_one("a5", 1'b0, 8'hA5);
    for (int i = 0; i < 8; i++) send(8'hFF, 1'b1);
    idle(2);
    check("b2b_count", got.size(), 8);
    foreach (got[i]) begin
      check("b2b_data", got[i].d, 8'hFF);
      check("b2b_brk", got[i].b, 0);
    end
    got.delete();
    idle(C);
    foreach (vecs[i]) begin
      en = vecs[i].en;
      send(vecs[i].d, vecs[i].stop);
      en = 1'b1;
      idle(C);
      check($sformatf("vec%0d_count", i), got.size(), {31'd0, vecs[i].exp_v});
      if (vecs[i].exp_v && got.size() > 0) begin
        check($sformatf("vec%0d_brk", i), got[0].b, vecs[i].exp_b);
        check($sformatf("vec%0d_data", i), got[0].d, vecs[i].exp_d);
      end
      got.delete();
    end
    rxd = 1'b0;
    idle(12 * C);
    expect_one("break", 1'b1, 8'h00);
    idle(3 * C);
    expect_none("break_hold");
    rxd = 1'b1;
    idle(C);
    send(8'h3C, 1'b1);
    idle(2);
    expect_one("after_break", 1'b0, 8'h3C);
    rxd = 1'b0;
    idle(C / 4);
    rxd = 1'b1;
    idle(2 * C);
    expect_none("glitch");
    send(8'h3C, 1'b1);
    idle(2);
    expect_one("after_glitch", 1'b0, 8'h3C);
    en = 1'b0;
    send(8'h55, 1'b1);
    idle(C);
    expect_none("en_off");
    d = 8'h55;
    rxd = 1'b0;
    idle(C);
    for (int i = 0; i < 7; i++) begin
      rxd = d[i];
      idle(C);
    end
    rxd = d[7];
    idle(C / 2);
    en = 1'b1;
    idle(C / 2);
    rxd = 1'b1;
    idle(2 * C);
    expect_none("en_mid");
    send(8'h55, 1'b1);
    idle(2);
    expect_one("en_next", 1'b0, 8'h55);
    rxd = 1'b0;
    idle(5 * C);
    rxd = 1'b1;
    idle(C / 2);
    resetn = 1'b0;
    idle(2);
    check("midrst_valid", valid, 0);
    check("midrst_brk", brk, 0);
    check("midrst_data", data, 0);
    resetn = 1'b1;
    idle(C / 2 + 5 * C);
    expect_none("midrst_frame");
    send(8'h81, 1'b1);
    idle(2);
    expect_one("after_rst", 1'b0, 8'h81);
    idle(C);
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      stop = ($urandom % 8) != 0;
      if ($urandom % 8 == 0) begin
        d = 8'h00;
        stop = 1'b0;
      end
      if (stop) exp_q.push_back('{1'b1, 1'b0, d, 0});
      else if (d == 8'h00) exp_q.push_back('{1'b1, 1'b1, 8'h00, 0});
      gap = stop ? int'($urandom % (2 * C)) : C + int'($urandom % C);
      send(d, stop);
      idle(gap);
    end
    idle(2 * C);
    check("rand_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("rand%0d_brk", i), got[i].b, exp_q[i].b);
      check($sformatf("rand%0d_data", i), got[i].d, exp_q[i].d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
